// File: rtl/axi_rr_master_arbiter.sv
// Round-robin arbiter: N cache/device clients share one AXI4 master port.
// One transaction is in flight at a time and the winner keeps the grant
// until its read burst or write response completes.
module axi_rr_master_arbiter #(
    parameter int N      = 3,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // client side
    input  logic [N-1:0]          c_req_valid,
    output logic [N-1:0]          c_req_ready,
    input  logic [N-1:0]          c_req_we,
    input  logic [N*ADDR_W-1:0]   c_req_addr,
    input  logic [N*8-1:0]        c_req_len,
    input  logic [N*3-1:0]        c_req_size,
    input  logic [N*DATA_W-1:0]   c_wdata,
    input  logic [N*STRB_W-1:0]   c_wstrb,
    output logic [N-1:0]          c_wbeat_ack,
    output logic [DATA_W-1:0]     c_rdata,
    output logic [N-1:0]          c_rvalid,
    output logic                  c_rlast,
    output logic [N-1:0]          c_done,
    output logic [1:0]            c_resp,
    // AXI4 write address
    output logic [ID_W-1:0]       axi_aw_id,
    output logic [ADDR_W-1:0]     axi_aw_addr,
    output logic [7:0]            axi_aw_len,
    output logic [2:0]            axi_aw_size,
    output logic [1:0]            axi_aw_burst,
    output logic                  axi_aw_valid,
    input  logic                  axi_aw_ready,
    // AXI4 write data
    output logic [DATA_W-1:0]     axi_w_data,
    output logic [STRB_W-1:0]     axi_w_strb,
    output logic                  axi_w_last,
    output logic                  axi_w_valid,
    input  logic                  axi_w_ready,
    // AXI4 write response
    input  logic [ID_W-1:0]       axi_b_id,
    input  logic [1:0]            axi_b_resp,
    input  logic                  axi_b_valid,
    output logic                  axi_b_ready,
    // AXI4 read address
    output logic [ID_W-1:0]       axi_ar_id,
    output logic [ADDR_W-1:0]     axi_ar_addr,
    output logic [7:0]            axi_ar_len,
    output logic [2:0]            axi_ar_size,
    output logic [1:0]            axi_ar_burst,
    output logic                  axi_ar_valid,
    input  logic                  axi_ar_ready,
    // AXI4 read data
    input  logic [ID_W-1:0]       axi_r_id,
    input  logic [DATA_W-1:0]     axi_r_data,
    input  logic [1:0]            axi_r_resp,
    input  logic                  axi_r_last,
    input  logic                  axi_r_valid,
    output logic                  axi_r_ready
);

    localparam int          IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned NU    = N;

    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, g, win, g_inc;
    logic             found;
    logic [N-1:0]     g_oh;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]       len_q;
    logic [2:0]       size_q;
    logic [7:0]       cnt;
    int unsigned      gi, wi;

    // Only one transaction is ever outstanding, so returned IDs carry no information.
    logic unused_ids;
    assign unused_ids = ^{axi_r_id, axi_b_id};

    assign gi    = 32'(g);
    assign wi    = 32'(win);
    assign g_oh  = N'(1) << g;
    assign g_inc = (g == IDX_W'(N - 1)) ? '0 : g + 1'b1;

    // Round-robin search: first requester at or after ptr, wrapping mod N.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < NU; k++) begin
            if (!found && c_req_valid[(32'(ptr) + k) % NU]) begin
                found = 1'b1;
                win   = IDX_W'((32'(ptr) + k) % NU);
            end
        end
    end

    // Latched request fields drive the address channels for the whole transaction.
    assign axi_ar_id    = ID_W'(g);
    assign axi_ar_addr  = addr_q;
    assign axi_ar_len   = len_q;
    assign axi_ar_size  = size_q;
    assign axi_ar_burst = 2'b01;
    assign axi_aw_id    = ID_W'(g);
    assign axi_aw_addr  = addr_q;
    assign axi_aw_len   = len_q;
    assign axi_aw_size  = size_q;
    assign axi_aw_burst = 2'b01;
    assign axi_w_data   = c_wdata[gi*DATA_W +: DATA_W];
    assign axi_w_strb   = c_wstrb[gi*STRB_W +: STRB_W];
    assign axi_w_last   = (cnt == len_q);
    assign c_rdata      = axi_r_data;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_n      = state;
        c_req_ready  = '0;
        c_wbeat_ack  = '0;
        c_rvalid     = '0;
        c_rlast      = 1'b0;
        c_done       = '0;
        c_resp       = 2'b00;
        axi_ar_valid = 1'b0;
        axi_aw_valid = 1'b0;
        axi_w_valid  = 1'b0;
        axi_r_ready  = 1'b0;
        axi_b_ready  = 1'b0;
        case (state)
            IDLE: if (found) begin
                c_req_ready = N'(1) << win;
                state_n     = c_req_we[win] ? AW : AR;
            end
            AR: begin
                axi_ar_valid = 1'b1;
                if (axi_ar_ready) state_n = R;
            end
            R: begin
                axi_r_ready = 1'b1;
                c_resp      = axi_r_resp;
                if (axi_r_valid) begin
                    c_rvalid = g_oh;
                    if (axi_r_last) begin
                        c_rlast = 1'b1;
                        c_done  = g_oh;
                        state_n = IDLE;
                    end
                end
            end
            AW: begin
                axi_aw_valid = 1'b1;
                if (axi_aw_ready) state_n = W;
            end
            W: begin
                axi_w_valid = 1'b1;
                if (axi_w_ready) begin
                    c_wbeat_ack = g_oh;
                    if (cnt == len_q) state_n = B;
                end
            end
            B: begin
                axi_b_ready = 1'b1;
                c_resp      = axi_b_resp;
                if (axi_b_valid) begin
                    c_done  = g_oh;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Grant capture, beat counter and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= '0;
            g      <= '0;
            addr_q <= '0;
            len_q  <= '0;
            size_q <= '0;
            cnt    <= '0;
        end else begin
            if (state == IDLE && found) begin
                g      <= win;
                addr_q <= c_req_addr[wi*ADDR_W +: ADDR_W];
                len_q  <= c_req_len[wi*8 +: 8];
                size_q <= c_req_size[wi*3 +: 3];
            end
            if (state == AW && axi_aw_ready) cnt <= '0;
            if (state == W && axi_w_ready && cnt != len_q) cnt <= cnt + 8'd1;
            if (|c_done) ptr <= g_inc;
        end
    end

endmodule

// File: tb/tb_axi_rr_master_arbiter.sv
// Scoreboard bench: client drivers queue expected transactions, a randomly
// stalling AXI slave model serves them, and a monitor checks every cycle.
module tb_axi_rr_master_arbiter;

    localparam int N = 3, DATA_W = 64, ADDR_W = 32, ID_W = 4, STRB_W = 8;
    localparam int LIM = 6000;

    typedef struct {
        int          client;
        bit          we;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [63:0] d0;
        logic [7:0]  strb;
    } txn_t;

    logic clk, rst;
    logic [N-1:0] c_req_valid, c_req_ready, c_req_we, c_wbeat_ack, c_rvalid, c_done;
    logic [N*ADDR_W-1:0] c_req_addr;
    logic [N*8-1:0] c_req_len;
    logic [N*3-1:0] c_req_size;
    logic [N*DATA_W-1:0] c_wdata;
    logic [N*STRB_W-1:0] c_wstrb;
    logic [DATA_W-1:0] c_rdata;
    logic c_rlast;
    logic [1:0] c_resp;
    logic [ID_W-1:0] axi_aw_id, axi_ar_id, axi_b_id, axi_r_id;
    logic [ADDR_W-1:0] axi_aw_addr, axi_ar_addr;
    logic [7:0] axi_aw_len, axi_ar_len;
    logic [2:0] axi_aw_size, axi_ar_size;
    logic [1:0] axi_aw_burst, axi_ar_burst, axi_b_resp, axi_r_resp;
    logic axi_aw_valid, axi_aw_ready, axi_w_last, axi_w_valid, axi_w_ready;
    logic axi_b_valid, axi_b_ready, axi_ar_valid, axi_ar_ready;
    logic axi_r_last, axi_r_valid, axi_r_ready;
    logic [DATA_W-1:0] axi_w_data, axi_r_data;
    logic [STRB_W-1:0] axi_w_strb;

    // per-client driver state
    bit          req_v_a[N];
    bit          we_a[N];
    logic [31:0] addr_a[N];
    logic [7:0]  len_a[N];
    logic [2:0]  size_a[N];
    logic [63:0] wdata_a[N];
    logic [7:0]  wstrb_a[N];

    int   vectors = 0, miscompares = 0, issued = 0, completed = 0;
    txn_t exp_q[$];
    int   grant_log[$];
    int   mon_rbeat = 0;

    axi_rr_master_arbiter #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
        .c_req_addr(c_req_addr), .c_req_len(c_req_len), .c_req_size(c_req_size),
        .c_wdata(c_wdata), .c_wstrb(c_wstrb), .c_wbeat_ack(c_wbeat_ack),
        .c_rdata(c_rdata), .c_rvalid(c_rvalid), .c_rlast(c_rlast), .c_done(c_done), .c_resp(c_resp),
        .axi_aw_id(axi_aw_id), .axi_aw_addr(axi_aw_addr), .axi_aw_len(axi_aw_len),
        .axi_aw_size(axi_aw_size), .axi_aw_burst(axi_aw_burst), .axi_aw_valid(axi_aw_valid),
        .axi_aw_ready(axi_aw_ready),
        .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
        .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
        .axi_b_id(axi_b_id), .axi_b_resp(axi_b_resp), .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready),
        .axi_ar_id(axi_ar_id), .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len),
        .axi_ar_size(axi_ar_size), .axi_ar_burst(axi_ar_burst), .axi_ar_valid(axi_ar_valid),
        .axi_ar_ready(axi_ar_ready),
        .axi_r_id(axi_r_id), .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last),
        .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pack the per-client arrays onto the flat DUT buses.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            c_req_valid[i] = req_v_a[i];
            c_req_we[i]    = we_a[i];
            c_req_addr[i*ADDR_W +: ADDR_W] = addr_a[i];
            c_req_len[i*8 +: 8]            = len_a[i];
            c_req_size[i*3 +: 3]           = size_a[i];
            c_wdata[i*DATA_W +: DATA_W]    = wdata_a[i];
            c_wstrb[i*STRB_W +: STRB_W]    = wstrb_a[i];
        end
    end

    // slave memory and response rules
    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'hA5A5_5A5A, ~a};
    endfunction
    function automatic logic [1:0] rresp_of(input logic [31:0] a, input int beat);
        return (a[31:28] == 4'hE && beat == 1) ? 2'b10 : 2'b00;
    endfunction
    function automatic logic [1:0] bresp_of(input logic [31:0] a);
        return (a[31:28] == 4'hD) ? 2'b11 : 2'b00;
    endfunction
    function automatic logic [63:0] wd(input logic [63:0] d0, input int beat);
        return d0 + 64'(beat) * 64'h11;
    endfunction

    function automatic txn_t mk(input int c, input bit we, input logic [31:0] a, input logic [7:0] len,
                                input logic [2:0] size, input logic [63:0] d0, input logic [7:0] strb);
        txn_t t;
        t.client = c; t.we = we; t.addr = a; t.len = len; t.size = size; t.d0 = d0; t.strb = strb;
        return t;
    endfunction

    function automatic txn_t rand_txn(input int c);
        logic [3:0] nib;
        logic [2:0] sz;
        logic [7:0] ln;
        int r;
        case ($urandom % 4)
            0: nib = 4'h8;
            1: nib = 4'hA;
            2: nib = 4'hD;
            default: nib = 4'hE;
        endcase
        sz = 3'($urandom % 4);
        r  = int'($urandom % 32);
        if (r == 0)      ln = 8'd0;
        else if (r == 1) ln = 8'd255;
        else             ln = 8'($urandom % 8);
        return mk(c, bit'($urandom % 2), {nib, 28'($urandom)} & ~((32'd1 << sz) - 32'd1), ln, sz,
                  {32'($urandom), 32'($urandom)}, 8'($urandom));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout expected handshake (t=%0t)", name, $time);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_req_ready"}, c_req_ready, 0);
        chk({tag, "_rvalid"}, c_rvalid, 0);
        chk({tag, "_rlast"}, c_rlast, 0);
        chk({tag, "_done"}, c_done, 0);
        chk({tag, "_wack"}, c_wbeat_ack, 0);
        chk({tag, "_ar_valid"}, axi_ar_valid, 0);
        chk({tag, "_aw_valid"}, axi_aw_valid, 0);
        chk({tag, "_w_valid"}, axi_w_valid, 0);
        chk({tag, "_r_ready"}, axi_r_ready, 0);
        chk({tag, "_b_ready"}, axi_b_ready, 0);
    endtask

    // ---------------- client drivers ----------------
    task automatic raise_req(input txn_t t);
        @(posedge clk); #1;
        req_v_a[t.client] = 1'b1;
        we_a[t.client]    = t.we;
        addr_a[t.client]  = t.addr;
        len_a[t.client]   = t.len;
        size_a[t.client]  = t.size;
        wdata_a[t.client] = wd(t.d0, 0);
        wstrb_a[t.client] = t.strb;
        exp_q.push_back(t);
    endtask

    // Waits for the grant, then drops the request and scrambles the fields,
    // which the arbiter must ignore from here on.
    task automatic wait_grant(input int i, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < LIM && !ok; n++) begin
            @(negedge clk);
            if (c_req_ready[i]) ok = 1'b1;
        end
        if (!ok) timeout("grant_wait");
        @(posedge clk); #1;
        req_v_a[i] = 1'b0;
        we_a[i]    = bit'($urandom % 2);
        addr_a[i]  = 32'($urandom);
        len_a[i]   = 8'($urandom);
        size_a[i]  = 3'($urandom);
    endtask

    task automatic run_client(input txn_t t);
        bit ok, done;
        int beat;
        issued++;
        raise_req(t);
        wait_grant(t.client, ok);
        if (ok) begin
            beat = 0;
            done = 1'b0;
            for (int n = 0; n < LIM && !done; n++) begin
                @(negedge clk);
                if (c_wbeat_ack[t.client]) beat++;
                if (c_done[t.client]) done = 1'b1;
                else begin
                    @(posedge clk); #1;
                    wdata_a[t.client] = wd(t.d0, beat);
                end
            end
            if (!done) timeout("done_wait");
        end
    endtask

    task automatic rand_client(input int i);
        for (int n = 0; n < 8; n++) begin
            txn_t t;
            t = rand_txn(i);
            repeat ($urandom % 4) @(posedge clk);
            run_client(t);
        end
    endtask

    // ---------------- AXI slave: read side ----------------
    initial begin
        bit srst, hs_ar, hs_r, rbusy;
        logic [31:0] ra;
        logic [7:0] rl;
        logic [2:0] rs;
        logic [ID_W-1:0] rid;
        int rb;
        rbusy = 0; rb = 0; ra = '0; rl = '0; rs = '0; rid = '0;
        axi_ar_ready = 0; axi_r_valid = 0; axi_r_data = '0; axi_r_resp = '0; axi_r_last = 0; axi_r_id = '0;
        forever begin
            @(negedge clk);
            srst  = rst;
            hs_ar = axi_ar_valid && axi_ar_ready;
            hs_r  = axi_r_valid && axi_r_ready;
            if (hs_ar) begin ra = axi_ar_addr; rl = axi_ar_len; rs = axi_ar_size; rid = axi_ar_id; end
            @(posedge clk); #1;
            if (srst) begin
                rbusy = 0; axi_ar_ready = 0; axi_r_valid = 0; axi_r_last = 0;
                continue;
            end
            if (hs_ar) begin rbusy = 1; rb = 0; end
            if (hs_r) begin
                if (rb == int'(rl)) rbusy = 0;
                rb++;
                axi_r_valid = 0;
            end
            axi_ar_ready = !rbusy && ($urandom % 2 == 1);
            if (rbusy && !axi_r_valid && ($urandom % 4 != 0)) begin
                axi_r_valid = 1;
                axi_r_data  = mem_word(ra + (32'(rb) << rs));
                axi_r_resp  = rresp_of(ra, rb);
                axi_r_last  = (rb == int'(rl));
                axi_r_id    = rid;
            end
        end
    end

    // ---------------- AXI slave: write side ----------------
    initial begin
        bit srst, hs_aw, hs_w, wl, hs_b, wph, bph;
        logic [31:0] wa;
        logic [ID_W-1:0] wid;
        int bdly;
        wph = 0; bph = 0; bdly = 0; wa = '0; wid = '0;
        axi_aw_ready = 0; axi_w_ready = 0; axi_b_valid = 0; axi_b_resp = '0; axi_b_id = '0;
        forever begin
            @(negedge clk);
            srst  = rst;
            hs_aw = axi_aw_valid && axi_aw_ready;
            hs_w  = axi_w_valid && axi_w_ready;
            wl    = axi_w_last;
            hs_b  = axi_b_valid && axi_b_ready;
            if (hs_aw) begin wa = axi_aw_addr; wid = axi_aw_id; end
            @(posedge clk); #1;
            if (srst) begin
                wph = 0; bph = 0; axi_aw_ready = 0; axi_w_ready = 0; axi_b_valid = 0;
                continue;
            end
            if (hs_aw) wph = 1;
            if (hs_w && wl) begin wph = 0; bph = 1; bdly = int'($urandom % 3); end
            if (hs_b) begin bph = 0; axi_b_valid = 0; end
            axi_aw_ready = !wph && !bph && ($urandom % 2 == 1);
            axi_w_ready  = wph && ($urandom % 4 != 0);
            if (bph && !axi_b_valid) begin
                if (bdly == 0) begin axi_b_valid = 1; axi_b_resp = bresp_of(wa); axi_b_id = wid; end
                else bdly--;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit   active, ar_done, aw_done, w_done;
        bit   exp_arv, exp_awv, exp_wv, exp_rr, exp_br, rhs, bhs, done_e;
        txn_t cur;
        int   mptr, exp_w, wbeat, idx;
        logic [N-1:0] oh;
        active = 0; ar_done = 0; aw_done = 0; w_done = 0; mptr = 0; wbeat = 0;
        cur = mk(0, 0, '0, '0, '0, '0, '0);
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0; mptr = 0;
                continue;
            end
            oh    = active ? (N'(1) << cur.client) : '0;
            exp_w = -1;
            if (!active) begin
                for (int k = 0; k < N; k++)
                    if (exp_w < 0 && c_req_valid[(mptr + k) % N]) exp_w = (mptr + k) % N;
                chk("grant", c_req_ready, (exp_w >= 0) ? (64'd1 << exp_w) : 64'd0);
            end else begin
                chk("ready_busy", c_req_ready, 0);
            end

            exp_arv = active && !cur.we && !ar_done;
            chk("ar_valid", axi_ar_valid, exp_arv);
            if (exp_arv && axi_ar_valid) begin
                chk("ar_id", axi_ar_id, cur.client);
                chk("ar_addr", axi_ar_addr, cur.addr);
                chk("ar_len", axi_ar_len, cur.len);
                chk("ar_size", axi_ar_size, cur.size);
                chk("ar_burst", axi_ar_burst, 2'b01);
            end
            exp_awv = active && cur.we && !aw_done;
            chk("aw_valid", axi_aw_valid, exp_awv);
            if (exp_awv && axi_aw_valid) begin
                chk("aw_id", axi_aw_id, cur.client);
                chk("aw_addr", axi_aw_addr, cur.addr);
                chk("aw_len", axi_aw_len, cur.len);
                chk("aw_size", axi_aw_size, cur.size);
                chk("aw_burst", axi_aw_burst, 2'b01);
            end
            exp_wv = active && cur.we && aw_done && !w_done;
            chk("w_valid", axi_w_valid, exp_wv);
            if (exp_wv && axi_w_valid) begin
                chk("w_data", axi_w_data, wd(cur.d0, wbeat));
                chk("w_strb", axi_w_strb, cur.strb);
                chk("w_last", axi_w_last, wbeat == int'(cur.len));
            end
            chk("wbeat_ack", c_wbeat_ack, (exp_wv && axi_w_ready) ? oh : '0);

            exp_rr = active && !cur.we && ar_done;
            chk("r_ready", axi_r_ready, exp_rr);
            rhs = exp_rr && axi_r_valid;
            chk("rvalid", c_rvalid, rhs ? oh : '0);
            if (rhs) begin
                chk("rdata", c_rdata, mem_word(cur.addr + (32'(mon_rbeat) << cur.size)));
                chk("rresp", c_resp, rresp_of(cur.addr, mon_rbeat));
            end
            chk("rlast", c_rlast, rhs && mon_rbeat == int'(cur.len));
            exp_br = active && cur.we && w_done;
            chk("b_ready", axi_b_ready, exp_br);
            bhs = exp_br && axi_b_valid;
            if (bhs) chk("bresp", c_resp, bresp_of(cur.addr));
            done_e = (rhs && mon_rbeat == int'(cur.len)) || bhs;
            chk("done", c_done, done_e ? oh : '0);

            // advance the reference model
            if (!active) begin
                if (exp_w >= 0) begin
                    idx = -1;
                    for (int k = 0; k < exp_q.size(); k++)
                        if (idx < 0 && exp_q[k].client == exp_w) idx = k;
                    if (idx < 0) begin
                        timeout("no_queued_txn");
                    end else begin
                        cur = exp_q[idx];
                        exp_q.delete(idx);
                        active = 1; ar_done = 0; aw_done = 0; w_done = 0;
                        wbeat = 0; mon_rbeat = 0;
                        grant_log.push_back(exp_w);
                    end
                end
            end else begin
                if (exp_arv && axi_ar_ready) ar_done = 1;
                if (exp_awv && axi_aw_ready) aw_done = 1;
                if (exp_wv && axi_w_ready) begin
                    if (wbeat == int'(cur.len)) w_done = 1;
                    wbeat++;
                end
                if (rhs) mon_rbeat++;
                if (done_e) begin
                    active = 0;
                    mptr = (cur.client + 1) % N;
                    completed++;
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        int n;
        txn_t t;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_v_a[i] = 0; we_a[i] = 0; addr_a[i] = '0; len_a[i] = '0;
            size_a[i] = '0; wdata_a[i] = '0; wstrb_a[i] = '0;
        end
        repeat (2) @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // reset in the middle of a len=7 read from client 0
        t = mk(0, 0, 32'h8000_1000, 8'd7, 3'd3, '0, 8'hFF);
        raise_req(t);
        wait_grant(0, ok);
        n = 0;
        while (mon_rbeat < 2 && n < LIM) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= LIM) timeout("reset_beats");
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_quiet("midreset");
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        run_client(mk(1, 0, 32'h8000_2000, 8'd2, 3'd3, '0, 8'hFF));

        // directed transactions
        run_client(mk(0, 0, 32'h8000_0000, 8'd3, 3'd3, '0, 8'hFF));
        run_client(mk(2, 1, 32'h8000_0100, 8'd1, 3'd3, 64'h11, 8'hFF));

        // simultaneous requests with ptr at 0
        grant_log.delete();
        fork
            begin
                run_client(mk(0, 0, 32'h8000_0200, 8'd1, 3'd3, '0, 8'hFF));
                run_client(mk(0, 1, 32'h8000_0300, 8'd0, 3'd2, 64'h5555, 8'h0F));
            end
            run_client(mk(1, 1, 32'h8000_0400, 8'd2, 3'd3, 64'hABCD, 8'hF0));
            run_client(mk(2, 0, 32'h8000_0500, 8'd0, 3'd1, '0, 8'hFF));
        join
        chk("order_len", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            chk("order_0", grant_log[0], 0);
            chk("order_1", grant_log[1], 1);
            chk("order_2", grant_log[2], 2);
            chk("order_3", grant_log[3], 0);
        end

        // error responses, single beat and maximum burst
        run_client(mk(0, 0, 32'hE000_0040, 8'd3, 3'd3, '0, 8'hFF));
        run_client(mk(1, 1, 32'hD000_0000, 8'd2, 3'd3, 64'h1234, 8'h3C));
        run_client(mk(2, 1, 32'h8000_0600, 8'd0, 3'd3, 64'h77, 8'h01));
        run_client(mk(1, 0, 32'hA000_0000, 8'd255, 3'd3, '0, 8'hFF));
        run_client(mk(0, 1, 32'h8000_0800, 8'd255, 3'd3, 64'h100, 8'hFF));

        // randomized contention from all clients
        fork
            rand_client(0);
            rand_client(1);
            rand_client(2);
        join

        repeat (4) @(negedge clk);
        chk("txn_completed", completed, issued);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
